// File: rtl/sram_responder.sv
// sram_responder
// Single-port synchronous SRAM behind an sram-like CPU memory port. Every
// enabled request gets a response exactly one cycle later: read data, or the
// merged word after a byte-masked write (write-through). Out-of-range requests
// respond with zero data and addr_err. Saturating read/write counters are
// provided for bring-up.
//
// Ports
//   clk         single clock, all state changes on posedge
//   reset       asynchronous, active-high; clears outputs and counters only
//   sram_en     request valid this cycle
//   sram_we     byte write enables, 4'b0 = read
//   sram_addr   byte address, bits [1:0] ignored
//   sram_wdata  write data, lane i = bits [8i+7:8i]
//   sram_rdata  response data (holds while idle)
//   resp_valid  sram_rdata belongs to the previous-cycle request
//   addr_err    previous-cycle request was out of range
//   rd_cnt      accepted in-range reads, saturating
//   wr_cnt      accepted in-range writes, saturating
module sram_responder #(
   parameter int          ADDR_WIDTH = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h1c000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sram_en,
   input  logic [3:0]  sram_we,
   input  logic [31:0] sram_addr,
   input  logic [31:0] sram_wdata,
   output logic [31:0] sram_rdata,
   output logic        resp_valid,
   output logic        addr_err,
   output logic [31:0] rd_cnt,
   output logic [31:0] wr_cnt
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [31:0]           mem [DEPTH];
   logic [31:0]           off;
   logic                  in_range;
   logic [ADDR_WIDTH-1:0] idx;
   logic [31:0]           merged;
   logic                  is_write;
   logic                  rd_fire;
   logic                  wr_fire;
   logic                  unused_addr_bits;

   // Offset wraps on purpose: addresses below BASE_ADDR become huge offsets
   // and fall out of range through the same upper-bit test.
   assign off              = sram_addr - BASE_ADDR;
   assign in_range         = (off[31:ADDR_WIDTH+2] == '0);
   assign idx              = off[ADDR_WIDTH+1:2];
   assign unused_addr_bits = ^off[1:0];

   assign is_write = (sram_we != 4'b0000);
   assign rd_fire  = sram_en && in_range && !is_write;
   assign wr_fire  = sram_en && in_range && is_write;

   // Word as it will look after this cycle; for a read (no lanes enabled) this
   // is just the stored word, so one path serves both response kinds.
   always_comb begin
      merged = mem[idx];
      for (int i = 0; i < 4; i++) begin
         if (sram_we[i]) merged[8*i +: 8] = sram_wdata[8*i +: 8];
      end
   end

   // Array has no reset so contents survive it; the reset term only blocks
   // writes from requests that arrive while reset is held.
   always_ff @(posedge clk) begin
      if (!reset && wr_fire) begin
         for (int i = 0; i < 4; i++) begin
            if (sram_we[i]) mem[idx][8*i +: 8] <= sram_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sram_rdata <= '0;
         resp_valid <= 1'b0;
         addr_err   <= 1'b0;
         rd_cnt     <= '0;
         wr_cnt     <= '0;
      end else begin
         resp_valid <= sram_en;
         addr_err   <= sram_en && !in_range;
         if (sram_en) begin
            sram_rdata <= in_range ? merged : 32'h0;
         end
         if (rd_fire && (rd_cnt != 32'hffffffff)) rd_cnt <= rd_cnt + 32'd1;
         if (wr_fire && (wr_cnt != 32'hffffffff)) wr_cnt <= wr_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_sram_responder.sv
module tb_sram_responder;

   localparam logic [31:0] BASE  = 32'h1c000000;
   localparam int          WORDS = 1024;

   logic        clk;
   logic        reset;
   logic        sram_en;
   logic [3:0]  sram_we;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic        resp_valid;
   logic        addr_err;
   logic [31:0] rd_cnt;
   logic [31:0] wr_cnt;

   sram_responder #(.ADDR_WIDTH(10), .BASE_ADDR(BASE)) dut (
      .clk        (clk),
      .reset      (reset),
      .sram_en    (sram_en),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .resp_valid (resp_valid),
      .addr_err   (addr_err),
      .rd_cnt     (rd_cnt),
      .wr_cnt     (wr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   logic [31:0] m_mem [WORDS];
   logic [31:0] m_rdata;
   logic        m_valid;
   logic        m_err;
   logic [31:0] m_rd;
   logic [31:0] m_wr;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".rdata"}, sram_rdata, m_rdata);
      chk({tag, ".valid"}, {31'b0, resp_valid}, {31'b0, m_valid});
      chk({tag, ".err"},   {31'b0, addr_err},   {31'b0, m_err});
      chk({tag, ".rd_cnt"}, rd_cnt, m_rd);
      chk({tag, ".wr_cnt"}, wr_cnt, m_wr);
   endtask

   // One request cycle: drive, predict from the model, clock, compare.
   task automatic step(input string tag, input logic en, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] off;
      logic [31:0] w;
      int          idx;
      sram_en    = en;
      sram_we    = we;
      sram_addr  = addr;
      sram_wdata = wdata;
      if (en) begin
         off = addr - BASE;
         if (off < 32'd4096) begin
            idx = int'(off / 4);
            w   = m_mem[idx];
            if (we != 4'b0) begin
               for (int i = 0; i < 4; i++)
                  if (we[i]) w[8*i +: 8] = wdata[8*i +: 8];
               m_mem[idx] = w;
               if (m_wr != 32'hffffffff) m_wr = m_wr + 1;
            end else if (m_rd != 32'hffffffff) begin
               m_rd = m_rd + 1;
            end
            m_rdata = w;
            m_err   = 1'b0;
         end else begin
            m_rdata = 32'h0;
            m_err   = 1'b1;
         end
         m_valid = 1'b1;
      end else begin
         m_valid = 1'b0;
         m_err   = 1'b0;
      end
      @(posedge clk);
      #1;
      chk_all(tag);
   endtask

   task automatic model_reset();
      m_rdata = 32'h0;
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_rd    = 32'h0;
      m_wr    = 32'h0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      #1;
      chk_all("reset");
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] w12;
      reset      = 1'b1;
      sram_en    = 1'b0;
      sram_we    = 4'h0;
      sram_addr  = 32'h0;
      sram_wdata = 32'h0;
      model_reset();
      #2;
      chk_all("por");
      @(negedge clk);
      reset = 1'b0;

      // give every word a known value so the model never predicts unknowns
      for (int i = 0; i < WORDS; i++)
         step("preload", 1'b1, 4'hf, BASE + 32'(4 * i), $urandom);

      do_reset();

      step("wr_dead", 1'b1, 4'hf, 32'h1c000010, 32'hdeadbeef);
      step("rd_dead", 1'b1, 4'h0, 32'h1c000010, 32'h0);

      step("pre_mask", 1'b1, 4'hf, 32'h1c000020, 32'h11223344);
      step("wr_mask",  1'b1, 4'b0101, 32'h1c000020, 32'haabbccdd);
      step("rd_mask",  1'b1, 4'h0, 32'h1c000020, 32'h0);
      chk("mask_val", sram_rdata, 32'h11bb33dd);

      step("hold_rd", 1'b1, 4'h0, 32'h1c000010, 32'h0);
      for (int i = 0; i < 3; i++) step("hold", 1'b0, 4'h0, 32'h0, 32'h0);
      chk("hold_val", sram_rdata, 32'hdeadbeef);

      step("rng_lo",   1'b1, 4'h0, 32'h1bfffffc, 32'h0);
      step("rng_hi",   1'b1, 4'h0, 32'h1c001000, 32'h0);
      step("rng_top",  1'b1, 4'h0, 32'h1c000ffc, 32'h0);
      step("rng_wr",   1'b1, 4'hf, 32'h1c001000, 32'h55555555);
      step("rng_w0",   1'b1, 4'h0, 32'h1c000000, 32'h0);

      step("ua_w0", 1'b1, 4'h0, 32'h1c000003, 32'h0);
      step("ua_w1", 1'b1, 4'h0, 32'h1c000004, 32'h0);
      step("ua_w2", 1'b1, 4'h0, 32'h1c000008, 32'h0);

      // randomized traffic, biased toward the range edges
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 5))
            0:       a = BASE - 32'(4 * $urandom_range(1, 4));
            1:       a = BASE + 32'h1000 + 32'($urandom_range(0, 15));
            2:       a = $urandom;
            default: a = BASE + 32'($urandom_range(0, 4095));
         endcase
         step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
              a, $urandom);
      end

      // async reset arriving mid-way through a write cycle
      w12 = m_mem[12];
      step("pre_rst", 1'b1, 4'h0, 32'h1c000010, 32'h0);
      sram_en    = 1'b1;
      sram_we    = 4'hf;
      sram_addr  = 32'h1c000030;
      sram_wdata = ~w12;
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      chk_all("midrst");
      @(posedge clk);
      #1;
      chk_all("midrst_edge");
      reset   = 1'b0;
      sram_en = 1'b0;
      step("rst_w12", 1'b1, 4'h0, 32'h1c000030, 32'h0);
      chk("w12_kept", sram_rdata, w12);

      // saturation of the read counter
      step("sat_idle", 1'b0, 4'h0, 32'h0, 32'h0);
      force dut.rd_cnt = 32'hfffffffe;
      #1;
      release dut.rd_cnt;
      #1;
      m_rd = 32'hfffffffe;
      chk("sat_load", rd_cnt, m_rd);
      step("sat_rd1", 1'b1, 4'h0, 32'h1c000100, 32'h0);
      step("sat_rd2", 1'b1, 4'h0, 32'h1c000104, 32'h0);
      chk("sat_val", rd_cnt, 32'hffffffff);
      step("sat_idle2", 1'b0, 4'h0, 32'h0, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sram_responder.md
# sram_responder

Synchronous single-port SRAM responder serving the CPU's sram-like memory port, such as the instruction fetch port (`inst_sram_*`) or the data port. It accepts one request per cycle. It returns read data exactly one cycle after an enabled request, which is the fixed latency the fetch stage relies on when it drives `pc_next` as the address. It also performs byte-masked writes, flags out-of-range accesses, and keeps saturating access counters for bring-up.

## Interface
- `ADDR_WIDTH`, 10: word-address bits; depth = 2^ADDR_WIDTH words.
- `BASE_ADDR`, 32'h1c000000: byte address mapped to word 0; must be aligned to 4·2^ADDR_WIDTH.
- `clk` input 1: single clock, all state updates on posedge.
- `reset` input 1: asynchronous, active-high; clears every output register and counter, not the memory array.
- `sram_en` input 1: request valid this cycle.
- `sram_we` input 4: byte write enables; 4'b0 = read.
- `sram_addr` input 32: byte address; bits [1:0] ignored.
- `sram_wdata` input 32: write data; lane i = bits [8i+7:8i].
- `sram_rdata` output 32: response data.
- `resp_valid` output 1: `sram_rdata` corresponds to the request of the previous cycle.
- `addr_err` output 1: previous-cycle request was out of range.
- `rd_cnt` output 32: accepted in-range reads, saturating at 32'hffffffff.
- `wr_cnt` output 32: accepted in-range writes (any `sram_we` bit set), saturating.

## Operation
- Index: `off = sram_addr - BASE_ADDR` (32-bit, wraps). In range iff `off[31:ADDR_WIDTH+2] == 0`. Word index = `off[ADDR_WIDTH+1:2]`.
- Read (`sram_en`=1, `sram_we`=0, in range): next edge `sram_rdata` <= mem[idx]. `resp_valid`<=1, `addr_err`<=0, `rd_cnt`++.
- Write (`sram_en`=1, `sram_we`!=0, in range): next edge each lane i with `sram_we[i]`=1 gets `sram_wdata` lane i. Other lanes are unchanged. `sram_rdata` <= the merged new word (write-through). `resp_valid`<=1, `wr_cnt`++.
- Out of range (`sram_en`=1): memory unchanged, `sram_rdata`<=0, `resp_valid`<=1, `addr_err`<=1, counters unchanged.
- Idle (`sram_en`=0): `resp_valid`<=0, `addr_err`<=0. `sram_rdata` holds its last value, so a stalled consumer re-samples stable data.
- Back-to-back: a read of a word written the previous cycle returns the written value. A read and a write cannot share a cycle (single port).
- Counters: increment only if not already all-ones. Both counters are 32-bit unsigned.

## Timing
- Latency: exactly 1 cycle from the `sram_en` edge to `sram_rdata`/`resp_valid`/`addr_err`. There are no wait states and no backpressure; a new request is accepted every cycle.
- Reset (async): on the rise of `reset`, immediately `sram_rdata`=0, `resp_valid`=0, `addr_err`=0, `rd_cnt`=0, `wr_cnt`=0. While `reset`=1, requests are ignored and no memory write occurs.
- Reset mid-operation: a request presented in a cycle that ends with `reset` high produces no response and no write. The first request after deassertion is served normally one cycle later.
- Memory contents survive reset. After power-up they are undefined until written.

## Test plan
- Reset, then write 32'hdeadbeef with `sram_we`=4'hf to 32'h1c000010, then read 32'h1c000010 -> cycle+1 of the write: `sram_rdata`=32'hdeadbeef, `resp_valid`=1. Cycle+1 of the read: 32'hdeadbeef, `rd_cnt`=1, `wr_cnt`=1.
- Byte mask: preload 32'h11223344 at 32'h1c000020, write 32'haabbccdd with `sram_we`=4'b0101 -> subsequent read returns 32'h11bb33dd.
- Hold: read 32'h1c000010 (data 32'hdeadbeef), then `sram_en`=0 for 3 cycles -> `sram_rdata` stays 32'hdeadbeef and `resp_valid`=0 in those cycles.
- Range: reads at 32'h1bfffffc and 32'h1c001000 -> `addr_err`=1, `sram_rdata`=0, `rd_cnt` unchanged. A read at 32'h1c000ffc has `addr_err`=0. A write at 32'h1c001000 does not alter word 0.
- Unaligned/stream: reads at 32'h1c000003, 32'h1c000004, 32'h1c000008 on consecutive cycles -> responses are words 0, 1, 2 on consecutive cycles.
- Async reset mid-stream: assert `reset` between edges during a write to 32'h1c000030 -> outputs are 0 before the next edge, word 12 keeps its prior value, and counters read 0. Force `rd_cnt` near 32'hffffffff and read twice -> `rd_cnt` saturates at 32'hffffffff.
